// File: rtl/led_pattern_counter.sv
// Parametrised LED pattern generator: up, down, Gray and bounce sequences with
// a prescaled automatic step, pause, manual single-step, and tick/wrap pulses.
module led_pattern_counter #(
    parameter int WIDTH       = 4,
    parameter int TICK_CYCLES = 12_500_000
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Enable,
    input  logic [1:0]       i_Mode,
    input  logic             i_Step,
    output logic [WIDTH-1:0] o_Count,
    output logic             o_Tick,
    output logic             o_Wrap
);

    localparam int               PW         = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [WIDTH-1:0] ALL_ONES   = '1;

    localparam logic [1:0] MODE_UP     = 2'd0;
    localparam logic [1:0] MODE_DOWN   = 2'd1;
    localparam logic [1:0] MODE_GRAY   = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    logic [1:0]       r_Mode;
    logic [WIDTH-1:0] r_Value;
    logic             r_Dir;
    logic [PW-1:0]    r_Presc;
    logic             r_Step_d;
    logic             r_Tick;
    logic             r_Wrap;

    logic [WIDTH-1:0] value_next;
    logic             dir_next;
    logic             wrap_next;
    logic [WIDTH-1:0] start_value;
    logic [WIDTH-1:0] gray_value;
    logic             mode_change;
    logic             auto_adv;
    logic             step_edge;
    logic             advance;

    // Only the incoming mode ever needs a start value (reset and mode change).
    assign start_value = (i_Mode == MODE_DOWN) ? ALL_ONES : '0;
    assign mode_change = (i_Mode != r_Mode);
    assign auto_adv    = i_Enable && (r_Presc == PRESC_LAST);
    assign step_edge   = i_Step && !r_Step_d && !i_Enable;
    assign advance     = auto_adv || step_edge;

    always_comb begin
        value_next = r_Value;
        dir_next   = r_Dir;
        wrap_next  = 1'b0;
        case (r_Mode)
            MODE_DOWN: begin
                value_next = r_Value - 1'b1;
                wrap_next  = (r_Value == '0);
            end
            MODE_BOUNCE: begin
                // Direction flips on the step that lands on an end point.
                if (!r_Dir) begin
                    value_next = r_Value + 1'b1;
                    wrap_next  = (r_Value == ALL_ONES - 1'b1);
                end else begin
                    value_next = r_Value - 1'b1;
                    wrap_next  = (r_Value == WIDTH'(1));
                end
                dir_next = wrap_next ? !r_Dir : r_Dir;
            end
            default: begin
                value_next = r_Value + 1'b1;
                wrap_next  = (r_Value == ALL_ONES);
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Mode   <= i_Mode;
            r_Value  <= start_value;
            r_Dir    <= 1'b0;
            r_Presc  <= '0;
            r_Step_d <= 1'b1;
            r_Tick   <= 1'b0;
            r_Wrap   <= 1'b0;
        end else begin
            r_Step_d <= i_Step;
            if (mode_change) begin
                r_Mode  <= i_Mode;
                r_Value <= start_value;
                r_Dir   <= 1'b0;
                r_Presc <= '0;
                r_Tick  <= 1'b0;
                r_Wrap  <= 1'b0;
            end else begin
                if (i_Enable) begin
                    r_Presc <= (r_Presc == PRESC_LAST) ? '0 : r_Presc + 1'b1;
                end
                r_Tick <= advance;
                r_Wrap <= advance && wrap_next;
                if (advance) begin
                    r_Value <= value_next;
                    r_Dir   <= dir_next;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_value[gi] = r_Value[gi] ^ r_Value[gi+1];
        end
    endgenerate
    assign gray_value[WIDTH-1] = r_Value[WIDTH-1];

    assign o_Count = (r_Mode == MODE_GRAY) ? gray_value : r_Value;
    assign o_Tick  = r_Tick;
    assign o_Wrap  = r_Wrap;

endmodule

// File: tb/tb_led_pattern_counter.sv
// Scoreboard bench for led_pattern_counter at WIDTH=4, TICK_CYCLES=50.
module tb_led_pattern_counter;

    localparam int WIDTH = 4;
    localparam int TICK  = 50;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             enable = 1'b1;
    logic [1:0]       mode   = 2'd0;
    logic             step   = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             wrap;

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             wr;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    led_pattern_counter #(.WIDTH(WIDTH), .TICK_CYCLES(TICK)) dut (
        .i_Clk   (clk),
        .i_Rst   (rst),
        .i_Enable(enable),
        .i_Mode  (mode),
        .i_Step  (step),
        .o_Count (count),
        .o_Tick  (tick),
        .o_Wrap  (wrap)
    );

    always #5 clk = ~clk;

    // Counts falling edges until o_Tick is seen; -1 if the budget runs out.
    task automatic wait_tick(input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!tick && waited < limit);
        if (!tick) waited = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; mode = 2'd0; enable = 1'b1; step = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({count, tick, wrap} !== {4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: count=%0d tick=%0b wrap=%0b expected 0 0 0", count, tick, wrap);
        end
        rst = 1'b0;
    endtask

    task automatic test_up;
        int waited;
        exp_t e;
        for (int i = 1; i <= 16; i++) sb.push_back('{cnt: 4'(i % 16), wr: (i == 16)});
        for (int i = 1; i <= 16; i++) begin
            wait_tick(TICK + 10, waited);
            e = sb.pop_front();
            checks++;
            if (waited !== TICK) begin
                failures++;
                $display("FAIL up_interval%0d: waited=%0d expected %0d", i, waited, TICK);
            end
            checks++;
            if ({count, wrap} !== {e.cnt, e.wr}) begin
                failures++;
                $display("FAIL up_step%0d: count=%0d wrap=%0b expected %0d %0b", i, count, wrap, e.cnt, e.wr);
            end
        end
    endtask

    task automatic test_down;
        int waited;
        exp_t e;
        repeat (20) @(negedge clk);
        mode = 2'd1;
        @(negedge clk);
        checks++;
        if ({count, tick} !== {4'd15, 1'b0}) begin
            failures++;
            $display("FAIL down_start: count=%0d tick=%0b expected 15 0", count, tick);
        end
        for (int i = 1; i <= 16; i++) sb.push_back('{cnt: 4'(15 - (i % 16)), wr: (i == 16)});
        for (int i = 1; i <= 16; i++) begin
            wait_tick(TICK + 10, waited);
            e = sb.pop_front();
            checks++;
            if (waited !== TICK) begin
                failures++;
                $display("FAIL down_interval%0d: waited=%0d expected %0d", i, waited, TICK);
            end
            checks++;
            if ({count, wrap} !== {e.cnt, e.wr}) begin
                failures++;
                $display("FAIL down_step%0d: count=%0d wrap=%0b expected %0d %0b", i, count, wrap, e.cnt, e.wr);
            end
        end
    endtask

    task automatic test_gray;
        int waited;
        exp_t e;
        logic [WIDTH-1:0] v, prev;
        mode = 2'd2;
        @(negedge clk);
        checks++;
        if ({count, tick} !== {4'd0, 1'b0}) begin
            failures++;
            $display("FAIL gray_start: count=%0d tick=%0b expected 0 0", count, tick);
        end
        for (int i = 1; i <= 16; i++) begin
            v = 4'(i % 16);
            sb.push_back('{cnt: v ^ (v >> 1), wr: (i == 16)});
        end
        prev = count;
        for (int i = 1; i <= 16; i++) begin
            wait_tick(TICK + 10, waited);
            e = sb.pop_front();
            checks++;
            if (waited !== TICK || $countones(count ^ prev) != 1) begin
                failures++;
                $display("FAIL gray_timing%0d: waited=%0d prev=%0d now=%0d expected %0d cycles, one bit change",
                         i, waited, prev, count, TICK);
            end
            checks++;
            if ({count, wrap} !== {e.cnt, e.wr}) begin
                failures++;
                $display("FAIL gray_step%0d: count=%0d wrap=%0b expected %0d %0b", i, count, wrap, e.cnt, e.wr);
            end
            prev = count;
        end
    endtask

    task automatic test_bounce;
        int waited;
        int v;
        exp_t e;
        mode = 2'd3;
        @(negedge clk);
        checks++;
        if ({count, tick} !== {4'd0, 1'b0}) begin
            failures++;
            $display("FAIL bounce_start: count=%0d tick=%0b expected 0 0", count, tick);
        end
        for (int k = 1; k <= 30; k++) begin
            v = (k <= 15) ? k : 30 - k;
            sb.push_back('{cnt: 4'(v), wr: (v == 15 || v == 0)});
        end
        for (int k = 1; k <= 30; k++) begin
            wait_tick(TICK + 10, waited);
            e = sb.pop_front();
            checks++;
            if (waited !== TICK || {count, wrap} !== {e.cnt, e.wr}) begin
                failures++;
                $display("FAIL bounce_step%0d: waited=%0d count=%0d wrap=%0b expected %0d %0d %0b",
                         k, waited, count, wrap, TICK, e.cnt, e.wr);
            end
        end
    endtask

    task automatic test_pause_step;
        int waited, nticks, pushed, bad;
        logic s;
        logic [WIDTH-1:0] base;
        exp_t e;
        mode = 2'd0;
        @(negedge clk);
        wait_tick(TICK + 10, waited);
        checks++;
        if (waited !== TICK || count !== 4'd1) begin
            failures++;
            $display("FAIL pause_pre: waited=%0d count=%0d expected %0d 1", waited, count, TICK);
        end
        repeat (20) @(negedge clk);
        enable = 1'b0;
        base   = count;
        nticks = 0;
        pushed = 0;
        for (int c = 0; c < 100; c++) begin
            s = (c == 5 || c == 15 || c == 25 || (c >= 40 && c < 50));
            if (s && !step) begin
                pushed++;
                sb.push_back('{cnt: base + 4'(pushed), wr: 1'b0});
            end
            step = s;
            @(negedge clk);
            if (tick) begin
                nticks++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL manual_extra: unexpected tick count=%0d", count);
                end else begin
                    e = sb.pop_front();
                    if ({count, wrap} !== {e.cnt, e.wr}) begin
                        failures++;
                        $display("FAIL manual_step: count=%0d wrap=%0b expected %0d %0b", count, wrap, e.cnt, e.wr);
                    end
                end
            end
        end
        checks++;
        if (nticks != 4 || count !== base + 4'd4) begin
            failures++;
            $display("FAIL manual_total: ticks=%0d count=%0d expected 4 %0d", nticks, count, base + 4'd4);
        end
        sb.delete();
        enable = 1'b1;
        wait_tick(TICK + 10, waited);
        checks++;
        if (waited !== 30 || count !== base + 4'd5) begin
            failures++;
            $display("FAIL resume_tick: waited=%0d count=%0d expected 30 %0d", waited, count, base + 4'd5);
        end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            step = (c % 10 == 3);
            @(negedge clk);
            if (tick || count !== base + 4'd5) bad++;
        end
        step = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL enabled_step_ignored: disturbed_cycles=%0d expected 0", bad);
        end
        wait_tick(TICK + 10, waited);
        checks++;
        if (waited !== 10 || count !== base + 4'd6) begin
            failures++;
            $display("FAIL post_step_tick: waited=%0d count=%0d expected 10 %0d", waited, count, base + 4'd6);
        end
    endtask

    task automatic test_mid_reset;
        int waited, guard;
        guard = 0;
        while (count !== 4'd9 && guard < 5) begin
            wait_tick(TICK + 10, waited);
            guard++;
        end
        checks++;
        if (count !== 4'd9) begin
            failures++;
            $display("FAIL reach_nine: count=%0d expected 9", count);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({count, tick, wrap} !== {4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset: count=%0d tick=%0b wrap=%0b expected 0 0 0", count, tick, wrap);
        end
        wait_tick(TICK + 10, waited);
        checks++;
        if (waited !== TICK || count !== 4'd1) begin
            failures++;
            $display("FAIL reset_first_tick: waited=%0d count=%0d expected %0d 1", waited, count, TICK);
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_gray();
        test_bounce();
        test_pause_step();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_counter.md
# led_pattern_counter

Parametrised successor to the 4-bit LED binary counter. It advances a WIDTH-bit pattern once every TICK_CYCLES enabled clock cycles and supports four run-time modes: up binary, down binary, Gray code and bounce. It also supports pause and manual single-step. It sits between the board clock and the LED/PMOD outputs, and also supplies a step pulse and a wrap flag to downstream logic.

## Interface
- WIDTH, 4: pattern width in bits; legal range 2..16.
- TICK_CYCLES, 12_500_000: enabled cycles per automatic step, which is 0.5 s at 25 MHz; minimum 2.

- i_Clk  in  1  system clock, 25 MHz on board.
- i_Rst  in  1  synchronous, active-high reset.
- i_Enable  in  1  high: automatic stepping runs; low: prescaler frozen and manual step allowed.
- i_Mode  in  2  0 = up, 1 = down, 2 = Gray, 3 = bounce.
- i_Step  in  1  manual advance; rising edge only; honoured only while i_Enable = 0.
- o_Count  out  WIDTH  displayed pattern.
- o_Tick  out  1  one-cycle pulse in the first cycle a new o_Count value is visible.
- o_Wrap  out  1  one-cycle pulse, coincident with o_Tick, when the step crossed the sequence boundary.

## Operation
- Internal state:
  - r_Value: WIDTH-bit sequence register.
  - r_Dir: bounce direction, 0 = up.
  - r_Mode: 2-bit active mode.
  - Prescaler: counts 0..TICK_CYCLES-1.
  - r_Step_d: previous i_Step.
- Start value per mode: all-ones for down, 0 for up, Gray and bounce.
- Advance event, priority lowest to highest:
  - Prescaler equals TICK_CYCLES-1 with i_Enable = 1. The prescaler reloads to 0.
  - Step edge: i_Step & ~r_Step_d & ~i_Enable.
- Per-mode step on an advance:
  - Up: r_Value + 1, modulo 2^WIDTH. Wrap on max -> 0.
  - Down: r_Value - 1, modulo 2^WIDTH. Wrap on 0 -> max.
  - Gray: r_Value + 1. o_Count = r_Value ^ (r_Value >> 1). Wrap when r_Value goes max -> 0, i.e. o_Count goes 100..0 -> 0.
  - Bounce: r_Value steps +1 while r_Dir = 0 and -1 while r_Dir = 1.
    - r_Dir flips on the step that reaches 2^WIDTH-1 or 0.
    - o_Wrap is asserted on those two steps.
    - Sequence is 0, 1 .. max, max-1 .. 0, 1 ...; period is 2*(2^WIDTH-1) steps.
- o_Count mapping: r_Value for up, down and bounce; Gray mapping for mode 2.
- Mode change, when i_Mode differs from r_Mode, in any cycle:
  - r_Mode <= i_Mode.
  - r_Value <= start value of the new mode.
  - r_Dir <= 0.
  - Prescaler <= 0.
  - Any advance in that cycle is discarded. o_Tick and o_Wrap stay 0.
- Pause (i_Enable = 0):
  - Prescaler holds its count and resumes from it on re-enable.
  - o_Count holds.
- Manual step:
  - A held-high i_Step gives exactly one step.
  - An edge that occurs while i_Enable = 1 is ignored and is not deferred.
- Reset:
  - r_Mode <= i_Mode; r_Value <= start value of that mode; r_Dir, prescaler, o_Tick, o_Wrap <= 0.
  - r_Step_d <= 1, so a step held through reset does not fire.
  - Reset overrides mode change, advance and step.

## Timing
- All outputs are registered or decoded only from registers. No combinational input-to-output path.
- Advance latency: the advance condition is true at edge N; the new o_Count, o_Tick and o_Wrap are visible after edge N, during cycle N+1.
- Automatic period: exactly TICK_CYCLES enabled cycles between consecutive o_Tick pulses. Disabled cycles are not counted.
- First automatic tick after reset release or mode change: TICK_CYCLES enabled cycles later.
- Manual step: i_Step rises before edge N; o_Count updates after edge N.
- o_Tick is never high on two consecutive cycles.

## Test plan
- Use WIDTH=4, TICK_CYCLES=50 throughout.
- Up count: reset with i_Mode=0, i_Enable=1.
  - o_Count = 0; steps 1..15, 0 at intervals of exactly 50 cycles.
  - o_Wrap only on the 15 -> 0 step.
- Down count: switch to i_Mode=1 mid-sequence.
  - o_Count = 15 the next cycle, with no o_Tick.
  - Reaches 14 after 50 cycles.
  - o_Wrap on 0 -> 15.
- Gray: i_Mode=2.
  - Sequence 0, 1, 3, 2, 6, 7, 5, 4, 12 .. 8, 0.
  - Each step changes exactly one bit; o_Wrap on 8 -> 0.
- Bounce: i_Mode=3.
  - Sequence 0..15 then 14..0; period 30 ticks.
  - o_Wrap on the steps that reach 15 and 0 only.
- Pause and step:
  - Drop i_Enable at 20 cycles into a period, hold it low 100 cycles, then restore it. Next tick comes 30 enabled cycles later.
  - While disabled, give 3 short i_Step pulses and 1 pulse held high for 10 cycles: o_Count advances by 4.
  - i_Step pulses while enabled: no change.
- Mid-run reset: assert i_Rst for 1 cycle at o_Count = 9 in mode 0.
  - Next cycle o_Count = 0, o_Tick = 0, o_Wrap = 0.
  - First step 50 cycles after release.
